uart_tx_serializer: RTL and testbench

- Transmit-side companion to the AXI-Lite/UART bridge: drains bytes from the bridge's 8-bit TX FIFO (registered-read, EMPTY flag) and serialises them onto a UART line.
- Frame format: 8N1 by default; optional parity and 2 stop bits.
- Bit period set by a runtime-writable clocks-per-bit divisor, mirroring the RX side's baud-rate write port.

---
 rtl/uart_tx_serializer.sv | 154 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter: drains bytes from a registered-read FIFO and shifts them out as
// start / data (LSB first) / optional parity / stop bits at a runtime clocks-per-bit rate.
module uart_tx_serializer #(
  parameter int unsigned FREQ_CLK     = 100_000_000,
  parameter int unsigned DATA_WDTH    = 8,
  parameter int unsigned DEFAULT_BAUD = 115200,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 fifo_empty_i,
  input  logic [DATA_WDTH-1:0] fifo_rdata_i,
  output logic                 fifo_re_o,
  input  logic                 baud_div_we_i,
  input  logic [15:0]          baud_div_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned      DIV_W     = 16;
  localparam int unsigned      CNT_W     = $clog2(DATA_WDTH + STOP_BITS) + 1;
  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(FREQ_CLK / DEFAULT_BAUD);
  localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(2);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WDTH - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [DIV_W-1:0]     div_reg;
  logic [DIV_W-1:0]     div_sh;
  logic [DIV_W-1:0]     tmr;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_WDTH-1:0] shift_reg;
  logic                 par_acc;
  logic                 bit_end;
  logic                 stop_pre;

  assign bit_end  = (tmr == div_sh - DIV_W'(1));
  // One cycle before the final stop-bit boundary, so done_o lands on the last frame cycle
  assign stop_pre = (tmr == div_sh - MIN_DIV) && (bit_cnt == LAST_STOP);

  // Runtime divisor; values below 2 clamp to 2
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_reg <= RESET_DIV;
    end else if (baud_div_we_i) begin
      div_reg <= (baud_div_i < MIN_DIV) ? MIN_DIV : baud_div_i;
    end
  end

  // Frame sequencer. The IDLE cycle carrying fifo_re_o is decided on the edge entering it,
  // which keeps back-to-back frames to exactly two line-high gap cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      tx_o      <= 1'b1;
      fifo_re_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      shift_reg <= '0;
      div_sh    <= RESET_DIV;
      tmr       <= '0;
      bit_cnt   <= '0;
      par_acc   <= 1'b0;
    end else begin
      fifo_re_o <= 1'b0;
      done_o    <= 1'b0;
      tmr       <= tmr + DIV_W'(1);
      case (state)
        IDLE: begin
          tmr    <= '0;
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
          if (fifo_re_o) begin
            busy_o <= 1'b1;
            state  <= FETCH;
          end else begin
            fifo_re_o <= ~fifo_empty_i;
          end
        end
        FETCH: begin
          shift_reg <= fifo_rdata_i;
          div_sh    <= div_reg;
          bit_cnt   <= '0;
          par_acc   <= 1'b0;
          tmr       <= '0;
          tx_o      <= 1'b0;
          state     <= START;
        end
        START: begin
          if (bit_end) begin
            tmr   <= '0;
            tx_o  <= shift_reg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            tmr       <= '0;
            shift_reg <= shift_reg >> 1;
            par_acc   <= par_acc ^ shift_reg[0];
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx_o  <= par_acc ^ shift_reg[0] ^ PAR_ODD;
                state <= PARITY;
              end else begin
                tx_o  <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              tx_o    <= shift_reg[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tmr   <= '0;
            tx_o  <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          tx_o <= 1'b1;
          if (stop_pre) begin
            done_o <= 1'b1;
          end
          if (bit_end) begin
            tmr <= '0;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt   <= '0;
              busy_o    <= 1'b0;
              fifo_re_o <= ~fifo_empty_i;
              state     <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          tx_o  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: three frame formats (8N1, 8E2, 8O1) fed from
// queue-backed FIFO models; a per-unit monitor checks every line cycle against expectations.
module tb_uart_tx_serializer;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       par;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  fifo_empty = 3'b111;
  logic [2:0]  fifo_re;
  logic [2:0]  tx;
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [7:0]  rdata0 = '0;
  logic [7:0]  rdata1 = '0;
  logic [7:0]  rdata2 = '0;
  logic        baud_we;
  logic [15:0] baud_div;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int uflow = 0;
  int overlap = 0;
  int stray_done = 0;

  exp_t       exp_q0[$];
  exp_t       exp_q1[$];
  exp_t       exp_q2[$];
  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  logic [7:0] fq2[$];
  int         re_log0[$];

  int re_cnt    [3] = '{0, 0, 0};
  int last_re   [3] = '{0, 0, 0};
  int start_cyc [3] = '{0, 0, 0};
  bit in_frame  [3] = '{0, 0, 0};
  int cfg_pe    [3] = '{0, 1, 1};
  int cfg_stop  [3] = '{1, 2, 1};

  uart_tx_serializer u_dut0 (
    .clk(clk), .resetn(resetn), .fifo_empty_i(fifo_empty[0]), .fifo_rdata_i(rdata0),
    .fifo_re_o(fifo_re[0]), .baud_div_we_i(baud_we), .baud_div_i(baud_div),
    .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]));

  uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .resetn(resetn), .fifo_empty_i(fifo_empty[1]), .fifo_rdata_i(rdata1),
    .fifo_re_o(fifo_re[1]), .baud_div_we_i(baud_we), .baud_div_i(baud_div),
    .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]));

  uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .resetn(resetn), .fifo_empty_i(fifo_empty[2]), .fifo_rdata_i(rdata2),
    .fifo_re_o(fifo_re[2]), .baud_div_we_i(baud_we), .baud_div_i(baud_div),
    .tx_o(tx[2]), .busy_o(busy[2]), .done_o(done[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read FIFO models: data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (fifo_re[0]) begin
      if (fq0.size() == 0) uflow++;
      else rdata0 <= fq0.pop_front();
    end
    if (fifo_re[1]) begin
      if (fq1.size() == 0) uflow++;
      else rdata1 <= fq1.pop_front();
    end
    if (fifo_re[2]) begin
      if (fq2.size() == 0) uflow++;
      else rdata2 <= fq2.pop_front();
    end
  end

  always @(negedge clk) begin
    fifo_empty[0] = (fq0.size() == 0);
    fifo_empty[1] = (fq1.size() == 0);
    fifo_empty[2] = (fq2.size() == 0);
    for (int u = 0; u < 3; u++) begin
      if (fifo_re[u] === 1'b1) begin
        re_cnt[u]++;
        last_re[u] = cyc;
        if (u == 0) re_log0.push_back(cyc);
      end
      if (fifo_re[u] === 1'b1 && done[u] === 1'b1) overlap++;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int exp_size(input int u);
    case (u)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic exp_t pop_exp(input int u);
    case (u)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  task automatic push(input int u, input logic [7:0] d, input int div, input logic par);
    exp_t e;
    e.data = d;
    e.div  = div;
    e.par  = par;
    case (u)
      0:       begin fq0.push_back(d); exp_q0.push_back(e); end
      1:       begin fq1.push_back(d); exp_q1.push_back(e); end
      default: begin fq2.push_back(d); exp_q2.push_back(e); end
    endcase
  endtask

  function automatic int exp_lvl(input int u, input exp_t e, input int b);
    if (b == 0) return 0;
    if (b <= 8) return int'(e.data[b-1]);
    if (b == 9 && cfg_pe[u] != 0) return int'(e.par);
    return 1;
  endfunction

  // Per-unit monitor: one comparison per line bit (2 = level changed inside the bit)
  task automatic monitor(input int u);
    exp_t       e;
    int         total, b, seen, done_k, done_n, busy_bad;
    bit         aborted;
    logic [7:0] dec;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1 || tx[u] !== 1'b0) begin
        if (resetn === 1'b1 && done[u] === 1'b1) stray_done++;
        continue;
      end
      chk($sformatf("u%0d frame_expected", u), int'(exp_size(u) > 0), 1);
      if (exp_size(u) == 0) begin
        while (tx[u] === 1'b0 && resetn === 1'b1) @(negedge clk);
        continue;
      end
      e = pop_exp(u);
      start_cyc[u] = cyc;
      in_frame[u] = 1'b1;
      chk($sformatf("u%0d re_to_start", u), cyc - last_re[u], 2);
      total = (1 + 8 + cfg_pe[u] + cfg_stop[u]) * e.div;
      done_k = -1; done_n = 0; busy_bad = 0; aborted = 1'b0; dec = '0; seen = 0;
      for (int k = 0; k < total; k++) begin
        if (k > 0) @(negedge clk);
        if (resetn !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        b = k / e.div;
        if (k % e.div == 0) seen = int'(tx[u]);
        else if (seen != int'(tx[u])) seen = 2;
        if (b >= 1 && b <= 8 && (k % e.div) == e.div / 2) dec[b-1] = tx[u];
        if (done[u] === 1'b1) begin done_n++; done_k = k; end
        if (busy[u] !== 1'b1) busy_bad++;
        if (k % e.div == e.div - 1)
          chk($sformatf("u%0d byte%02h bit%0d", u, e.data, b), seen, exp_lvl(u, e, b));
      end
      in_frame[u] = 1'b0;
      if (!aborted) begin
        chk($sformatf("u%0d decoded_byte", u), int'(dec), int'(e.data));
        chk($sformatf("u%0d done_cycle", u), done_k, total - 1);
        chk($sformatf("u%0d done_pulses", u), done_n, 1);
        chk($sformatf("u%0d busy_low_cycles", u), busy_bad, 0);
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  task automatic set_div(input logic [15:0] v);
    @(negedge clk);
    baud_we  = 1'b1;
    baud_div = v;
    @(negedge clk);
    baud_we  = 1'b0;
  endtask

  task automatic wait_idle(input int u, input int budget);
    int n = 0;
    while ((exp_size(u) != 0 || in_frame[u]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d drained_in_budget", u), int'(n < budget), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_start(input int u);
    int n = 0;
    while (!in_frame[u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d frame_started", u), int'(in_frame[u]), 1);
  endtask

  initial begin
    int r, bad_tx, bad_busy, n;
    resetn   = 1'b0;
    baud_we  = 1'b0;
    baud_div = '0;
    repeat (3) @(negedge clk);
    chk("in_reset tx", int'(tx[0]), 1);
    chk("in_reset busy", int'(busy[0]), 0);
    chk("in_reset re", int'(fifo_re[0]), 0);
    chk("in_reset done", int'(done[0]), 0);
    resetn = 1'b1;

    // Idle with empty FIFO: line high, no reads
    r = re_cnt[0]; bad_tx = 0; bad_busy = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx[0] !== 1'b1) bad_tx++;
      if (busy[0] !== 1'b0) bad_busy++;
    end
    chk("idle tx_not_high_cycles", bad_tx, 0);
    chk("idle busy_cycles", bad_busy, 0);
    chk("idle re_pulses", re_cnt[0] - r, 0);

    // Single byte 0x55 at 4 clocks/bit
    set_div(16'd4);
    r = re_cnt[0];
    push(0, 8'h55, 4, 1'b0);
    wait_idle(0, 2000);
    chk("single re_pulses", re_cnt[0] - r, 1);
    chk("single busy_after", int'(busy[0]), 0);

    // Back-to-back frames: 10 bits * 4 + 2 gap cycles between reads
    re_log0.delete();
    push(0, 8'hA3, 4, 1'b0);
    push(0, 8'h0F, 4, 1'b0);
    push(0, 8'hFF, 4, 1'b0);
    wait_idle(0, 2000);
    chk("b2b re_pulses", re_log0.size(), 3);
    for (int i = 1; i < re_log0.size(); i++)
      chk($sformatf("b2b re_spacing%0d", i), re_log0[i] - re_log0[i-1], 42);
    chk("b2b busy_after", int'(busy[0]), 0);

    // Parity: even/2-stop on unit 1, odd/1-stop on unit 2
    push(1, 8'h07, 4, 1'b1);
    push(2, 8'h07, 4, 1'b0);
    push(2, 8'h00, 4, 1'b1);
    wait_idle(1, 2000);
    wait_idle(2, 2000);

    // Divisor write mid-frame applies to the following frame only
    push(0, 8'h3C, 4, 1'b0);
    push(0, 8'hC3, 8, 1'b0);
    wait_start(0);
    repeat (10) @(negedge clk);
    set_div(16'd8);
    wait_idle(0, 2000);
    set_div(16'd0);
    push(0, 8'h96, 2, 1'b0);
    wait_idle(0, 2000);

    // Reset during data bit 3 (a 0 bit of 0xA5); divisor returns to 868 afterwards
    set_div(16'd4);
    r = re_cnt[0];
    push(0, 8'hA5, 4, 1'b0);
    push(0, 8'h81, 868, 1'b0);
    wait_start(0);
    n = 0;
    while (cyc < start_cyc[0] + 17 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midreset tx_before", int'(tx[0]), 0);
    #2 resetn = 1'b0;
    #1;
    chk("midreset tx_async_high", int'(tx[0]), 1);
    chk("midreset busy", int'(busy[0]), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    wait_idle(0, 12000);
    chk("midreset re_pulses", re_cnt[0] - r, 2);
    chk("midreset fifo_left", fq0.size(), 0);

    chk("re_done_overlap", overlap, 0);
    chk("fifo_underflow", uflow, 0);
    chk("stray_done", stray_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
